// File: rtl/proc_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its program memory and the processor.
// master: the sequencer side; slave: memory/processor/control side.
interface proc_fetch_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              Start;
  logic              Done;
  logic [8:0]        MemData;
  logic [ADDR_W-1:0] MemAddr;
  logic [8:0]        DIN;
  logic              Run;
  logic              Busy;
  logic              Halted;
  logic              Error;
  logic [15:0]       InstrCnt;

  modport master (
    input  Start, Done, MemData,
    output MemAddr, DIN, Run, Busy, Halted, Error, InstrCnt
  );

  modport slave (
    output Start, Done, MemData,
    input  MemAddr, DIN, Run, Busy, Halted, Error, InstrCnt
  );
endinterface

// File: rtl/proc_fetch_sequencer.sv
// Fetch/issue controller for the 9-bit mv/mvi/add/sub processor.
// Fetches from a 1-cycle-latency program memory, issues words on DIN/Run,
// supplies the mvi immediate and waits for processor Done before refetching.
// Optional single-step mode: define SEQ_STEP_EN to add the Step input and PAUSE state.
module proc_fetch_sequencer #(
  parameter int          ADDR_W  = 5,
  parameter logic [2:0]  HALT_OP = 3'b111,
  parameter int          TIMEOUT = 8
) (
  input  logic                   Clock,
  input  logic                   Resetn,
`ifdef SEQ_STEP_EN
  input  logic                   Step,
`endif
  proc_fetch_sequencer_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_IMM,
    S_EXEC,
    S_HALTED,
    S_ERROR,
    S_PAUSE
  } state_t;

`ifdef SEQ_STEP_EN
  localparam state_t RETIRE_TO = S_PAUSE;
`else
  localparam state_t RETIRE_TO = S_FETCH;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        din;
  logic              run;
  logic              busy;
  logic [2:0]        op;

  assign op = bus.MemData[8:6];

  // State, PC, counters and sticky flags; Resetn clears everything at once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      wdog_q   <= wdog_d;
    end
  end

  // Next-state, PC update and processor/memory drive for the current state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    error_d  = error_q;
    wdog_d   = wdog_q;
    mem_addr = pc_q;
    din      = '0;
    run      = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (bus.Start) begin
          state_d  = S_FETCH;
          pc_d     = '0;
          cnt_d    = '0;
          halted_d = 1'b0;
          error_d  = 1'b0;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Address the following word now so an mvi immediate arrives in IMM.
        busy     = 1'b1;
        mem_addr = pc_q + ADDR_W'(1);
        din      = bus.MemData;
        wdog_d   = '0;
        if (op == HALT_OP) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          run     = 1'b1;
          state_d = (op == OP_MVI) ? S_IMM : S_EXEC;
        end
      end
      S_IMM, S_EXEC: begin
        busy = 1'b1;
        if (state_q == S_IMM) din = bus.MemData;
        if (bus.Done) begin
          pc_d    = pc_q + ((state_q == S_IMM) ? ADDR_W'(2) : ADDR_W'(1));
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
          state_d = RETIRE_TO;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
`ifdef SEQ_STEP_EN
      S_PAUSE: begin
        busy = 1'b1;
        if (Step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.MemAddr  = mem_addr;
  assign bus.DIN      = din;
  assign bus.Run      = run;
  assign bus.Busy     = busy;
  assign bus.Halted   = halted_q;
  assign bus.Error    = error_q;
  assign bus.InstrCnt = cnt_q;

endmodule

// File: tb/tb_proc_fetch_sequencer.sv
// Bench for proc_fetch_sequencer: builds the expected cycle trace of each program run
// from the instruction-level rules, plays its Start/Done/Step stimulus and compares
// the DUT outputs against the trace every cycle.
module tb_proc_fetch_sequencer;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = TIMEOUT + 1;
`ifdef SEQ_STEP_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  logic Step   = 1'b0;

  proc_fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  proc_fetch_sequencer #(
    .ADDR_W (ADDR_W),
    .HALT_OP(3'b111),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
`ifdef SEQ_STEP_EN
    .Step  (Step),
`endif
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read program memory.
  logic [8:0] mem [DEPTH];
  always @(posedge Clock) bus.MemData <= mem[bus.MemAddr];

  typedef struct {
    logic              start, done, step;
    logic [ADDR_W-1:0] addr;
    logic [8:0]        din;
    logic              run, busy, halted, error;
    logic [15:0]       cnt;
  } cyc_t;

  cyc_t tq[$];
  cyc_t cur;
  logic chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   busy_n;
  int   cyc_no = 0;

  // Architectural model state.
  logic [ADDR_W-1:0] m_pc     = '0;
  logic [15:0]       m_cnt    = '0;
  logic              m_halted = 1'b0;
  logic              m_err    = 1'b0;
  logic              trunc;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  // One expected cycle; data-bearing cycles show the word addressed in the previous cycle.
  task automatic push_cyc(input logic st, input logic dn, input logic sp,
                          input logic [ADDR_W-1:0] a, input logic use_mem,
                          input logic r, input logic b);
    cyc_t c;
    c.start  = st;
    c.done   = dn;
    c.step   = sp;
    c.addr   = a;
    c.din    = use_mem ? mem[tq[tq.size()-1].addr] : 9'h000;
    c.run    = r;
    c.busy   = b;
    c.halted = m_halted;
    c.error  = m_err;
    c.cnt    = m_cnt;
    tq.push_back(c);
  endtask

  function automatic int delay_for(input logic [2:0] op, input int mode);
    int nominal;
    nominal = (op <= 3'd1) ? 1 : (op <= 3'd3) ? 3 : NEVER;
    if (mode == 2 || op >= 3'd4) return NEVER;
    if (mode == 1 && $urandom_range(0, 1) == 1) return int'($urandom_range(1, NEVER));
    return nominal;
  endfunction

  function automatic logic nz(input bit noise);
    return noise ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  // Expected trace of one run: Start from an idle/halted/error state until HALT,
  // timeout, or `cap` retired instructions (then the run is cut mid-instruction).
  task automatic build(input int mode, input int cap, input bit noise, input bit fixed_pause);
    logic [ADDR_W-1:0] nxt;
    logic [8:0]        w;
    logic [2:0]        op;
    int                d, n, p;
    tq.delete();
    trunc = 1'b0;
    push_cyc(1'b1, nz(noise), 1'b0, m_pc, 1'b0, 1'b0, 1'b0);
    m_pc = '0; m_cnt = '0; m_halted = 1'b0; m_err = 1'b0;
    n = 0;
    forever begin
      push_cyc(nz(noise), nz(noise), 1'b0, m_pc, 1'b0, 1'b0, 1'b1);
      if (n == cap) begin
        trunc = 1'b1;
        break;
      end
      w   = mem[m_pc];
      op  = w[8:6];
      nxt = m_pc + ADDR_W'(1);
      push_cyc(nz(noise), nz(noise), 1'b0, nxt, 1'b1, op != 3'b111, 1'b1);
      if (op == 3'b111) begin
        m_halted = 1'b1;
        push_cyc(1'b0, nz(noise), 1'b0, m_pc, 1'b0, 1'b0, 1'b0);
        break;
      end
      d = delay_for(op, mode);
      for (int k = 1; k <= TIMEOUT && k <= d; k++)
        push_cyc(nz(noise), k == d, 1'b0, m_pc, op == 3'b001, 1'b0, 1'b1);
      if (d > TIMEOUT) begin
        m_err = 1'b1;
        push_cyc(1'b0, nz(noise), 1'b0, m_pc, 1'b0, 1'b0, 1'b0);
        break;
      end
      m_pc  = m_pc + ((op == 3'b001) ? ADDR_W'(2) : ADDR_W'(1));
      m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      n++;
      if (PX == 1) begin
        p = fixed_pause ? 1 : int'($urandom_range(1, 3));
        for (int j = 1; j <= p; j++)
          push_cyc(nz(noise), nz(noise), j == p, m_pc, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, 16'(bus.MemAddr), 16'h0);
    check({tag, "_din"},  16'(bus.DIN), 16'h0);
    check({tag, "_run"},  16'(bus.Run), 16'h0);
    check({tag, "_busy"}, 16'(bus.Busy), 16'h0);
    check({tag, "_halt"}, 16'(bus.Halted), 16'h0);
    check({tag, "_err"},  16'(bus.Error), 16'h0);
    check({tag, "_cnt"},  bus.InstrCnt, 16'h0);
  endtask

  task automatic do_reset();
    bus.Start = 1'b0;
    bus.Done  = 1'b0;
    Step      = 1'b0;
    Resetn    = 1'b0;
    #1;
    check_zero("rst");
    @(negedge Clock);
    #1 Resetn = 1'b1;
    m_pc = '0; m_cnt = '0; m_halted = 1'b0; m_err = 1'b0;
  endtask

  task automatic play();
    busy_n = 0;
    foreach (tq[i]) begin
      @(posedge Clock);
      #1;
      cur       = tq[i];
      bus.Start = cur.start;
      bus.Done  = cur.done;
      Step      = cur.step;
      chk_en    = 1'b1;
      if (bus.Busy) busy_n++;
    end
    @(posedge Clock);
    #1;
    chk_en    = 1'b0;
    bus.Start = 1'b0;
    bus.Done  = 1'b0;
    Step      = 1'b0;
    if (trunc) do_reset();
  endtask

  // Per-cycle comparison of all outputs against the expected trace.
  always @(negedge Clock) begin
    cyc_no++;
    if (chk_en) begin
      check("MemAddr",  16'(bus.MemAddr), 16'(cur.addr));
      check("DIN",      16'(bus.DIN), 16'(cur.din));
      check("Run",      16'(bus.Run), 16'(cur.run));
      check("Busy",     16'(bus.Busy), 16'(cur.busy));
      check("Halted",   16'(bus.Halted), 16'(cur.halted));
      check("Error",    16'(bus.Error), 16'(cur.error));
      check("InstrCnt", bus.InstrCnt, cur.cnt);
    end
  end

  task automatic fill_halt();
    for (int i = 0; i < DEPTH; i++) mem[i] = 9'h1C0;
  endtask

  task automatic fill_random();
    int r;
    logic [2:0] op;
    for (int i = 0; i < DEPTH; i++) begin
      r  = int'($urandom_range(0, 99));
      op = (r < 30) ? 3'd0 : (r < 55) ? 3'd1 : (r < 75) ? 3'd2 :
           (r < 90) ? 3'd3 : (r < 94) ? 3'($urandom_range(4, 6)) : 3'd7;
      mem[i] = {op, 6'($urandom)};
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Done  = 1'b0;
    fill_halt();

    // Reset held with Start toggling: everything stays at reset values.
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock);
      #1 bus.Start = ~bus.Start;
      #2 check_zero("hold");
    end
    bus.Start = 1'b0;
    @(negedge Clock);
    #1 Resetn = 1'b1;
    @(posedge Clock);
    #1 check("idle_busy", 16'(bus.Busy), 16'h0);

    // mvi r0,#5 ; HALT
    mem[0] = 9'h040; mem[1] = 9'h005; mem[2] = 9'h1C0;
    build(0, 1000, 1'b0, 1'b1);
    check("t2_len",    16'(tq.size()), 16'(7 + PX));
    check("t2_issue",  16'(tq[2].din), 16'h040);
    check("t2_imm",    16'(tq[3].din), 16'h005);
    play();
    check("t2_halted", 16'(bus.Halted), 16'h1);
    check("t2_cnt",    bus.InstrCnt, 16'd1);
    check("t2_pc",     16'(bus.MemAddr), 16'd2);
    check("t2_busy",   16'(busy_n), 16'(5 + PX));

    // mvi r1,#3 ; mv r2,r1 ; add ; HALT
    fill_halt();
    mem[0] = 9'h048; mem[1] = 9'h003; mem[2] = 9'h011; mem[3] = 9'h0A1;
    build(0, 1000, 1'b0, 1'b1);
    check("t3_len",  16'(tq.size()), 16'(15 + 3 * PX));
    play();
    check("t3_cnt",  bus.InstrCnt, 16'd3);
    check("t3_pc",   16'(bus.MemAddr), 16'd4);
    check("t3_busy", 16'(busy_n), 16'(13 + 3 * PX));

    // Done never arrives: error after exactly TIMEOUT EXEC cycles.
    fill_halt();
    mem[0] = 9'h000;
    build(2, 1000, 1'b0, 1'b1);
    play();
    check("t4_error", 16'(bus.Error), 16'h1);
    check("t4_busy",  16'(busy_n), 16'(2 + TIMEOUT));
    check("t4_cnt",   bus.InstrCnt, 16'd0);

    // Start from ERROR clears it and restarts at 0.
    mem[0] = 9'h040; mem[1] = 9'h005; mem[2] = 9'h1C0;
    build(0, 1000, 1'b0, 1'b1);
    play();
    check("t4b_error",  16'(bus.Error), 16'h0);
    check("t4b_halted", 16'(bus.Halted), 16'h1);

    // mvi at last address: immediate from word 0, next fetch at 1.
    mem[0] = 9'h00A;
    for (int i = 1; i < DEPTH - 1; i++) mem[i] = {3'b000, 6'($urandom)};
    mem[DEPTH-1] = 9'h040;
    build(0, DEPTH + 2, 1'b0, 1'b1);
    check("t5_iss_addr", 16'(tq[1 + 3 * (DEPTH - 1) + PX * (DEPTH - 1) + 1].addr), 16'd0);
    check("t5_imm_din",  16'(tq[1 + 3 * (DEPTH - 1) + PX * (DEPTH - 1) + 2].din), 16'h00A);
    check("t5_next",     16'(tq[1 + 3 * DEPTH + PX * DEPTH].addr), 16'd1);
    play();

    // Randomized programs, Done timing and ignored Start/Done noise.
    for (int t = 0; t < 60; t++) begin
      fill_random();
      build(1, int'($urandom_range(1, 30)), 1'b1, 1'b0);
      play();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
